pacman_motion_controller: RTL
=============================

Name: pacman_motion_controller

Overview:
- Computes the Pac-Man sprite position once per video frame and supplies it to the character generator: position_x, position_y, orientation and a position_ready strobe.
- Consumes a per-frame tick from the VGA timing logic and direction requests from the input path.
- Checks walls through a 1-bit maze map read port with 1-cycle read latency.
- Single pixel-clock domain.

Parameters:
- TILE_SIZE, 16, pixels per maze tile edge; power of two.
- MAP_COLS, 40, maze width in tiles.
- MAP_ROWS, 30, maze height in tiles.
- START_X, 304, reset x position in pixels; must be tile-aligned.
- START_Y, 352, reset y position in pixels; must be tile-aligned.
- SPEED_DIV, 1, frames per 1-pixel step; range 1..15.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  single-cycle pulse at start of each frame
- dir_req  in  2  requested direction (ORIENT_* encoding)
- dir_req_valid  in  1  qualifies dir_req for one cycle
- map_rd  out  1  maze read strobe
- map_addr  out  11  tile index = row*MAP_COLS + col
- map_wall  in  1  wall bit; valid the cycle after map_rd
- position_x  out  12  sprite top-left x, pixels
- position_y  out  12  sprite top-left y, pixels
- orientation  out  2  current travel direction
- position_ready  out  1  one-cycle strobe; new position valid

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - position_x=START_X, position_y=START_Y, orientation=ORIENT_LEFT.
  - position_ready=0, map_rd=0, map_addr=0.
  - pending request cleared, frame counter=0, FSM=IDLE.
  - reset asserted mid-sequence aborts immediately, with no position_ready.
- Encoding: 0=RIGHT, 1=UP, 2=LEFT, 3=DOWN. The reverse of d is d^2.
- Pending request:
  - dir_req_valid stores dir_req; the latest request wins.
  - It is held across frames until applied.
  - If a new request arrives in the same cycle the old one is consumed, the new one is kept.
- Move tick:
  - The frame counter counts frame_start pulses.
  - A frame is a move frame when counter==SPEED_DIV-1; the counter then wraps to 0.
- FSM: IDLE -> TURN_RD -> TURN_WAIT -> FWD_RD -> FWD_WAIT -> UPDATE -> IDLE. Fixed length; every state lasts one cycle.
  - IDLE: waits for frame_start. frame_start seen outside IDLE is dropped and the frame counter is not advanced.
  - TURN_RD: if a request is pending, differs from orientation, is not the reverse, and the position is tile-aligned (x,y both multiples of TILE_SIZE), issue map_rd for the neighbour tile in the requested direction.
  - TURN_WAIT: if a read was issued and map_wall==0, orientation takes the request and the pending request is cleared.
    - A reverse request is applied here unconditionally, with no read.
    - A request equal to orientation is cleared.
  - FWD_RD: if aligned, issue map_rd for the neighbour tile in the (possibly new) orientation. If not aligned, the path is clear without a read.
  - FWD_WAIT: sample map_wall into the blocked flag.
  - UPDATE: if this is a move frame and the sprite is not blocked, step 1 pixel in orientation. position_ready=1 for this single cycle, whether or not the sprite moved.
- Latency: frame_start sampled at edge N -> position_ready high and new outputs valid in the cycle after edge N+5.
- Neighbour tile computation, with col=x/TILE_SIZE and row=y/TILE_SIZE:
  - LEFT from col 0 uses col MAP_COLS-1 (tunnel).
  - RIGHT from the last col uses col 0.
  - UP from row 0 or DOWN from row MAP_ROWS-1 is treated as a wall, with no map_rd.
- Horizontal wrap:
  - x=0 moving LEFT -> x=(MAP_COLS-1)*TILE_SIZE.
  - x=(MAP_COLS-1)*TILE_SIZE moving RIGHT -> x=0.
  - No vertical wrap.
- map_rd is high for exactly one cycle per read. map_addr holds its value until the next read.

Decomposition:
- Package pacman_pkg holds:
  - ORIENT_RIGHT/UP/LEFT/DOWN constants and the 2-bit orientation type.
  - The FSM state enum.
  - The TILE_SIZE/MAP_COLS/MAP_ROWS defaults.
- One sub-module, pacman_tile_lookup (combinational): x, y and direction in -> neighbour map_addr, a force_wall flag for the edge cases, and an aligned flag.

Test Plan:
- Reset, then frame_start with map_wall=0, no request -> position_ready 6 cycles later with x=303, y=352, orientation=2; map_rd pulsed once with addr=22*40+18=898.
- Aligned at (304,352), request UP, map_wall=0 on both reads -> orientation=1, y=351; pending request cleared.
- Request UP with the turn read returning 1 -> orientation stays 2; request retained; later succeeds at the next aligned tile with map_wall=0.
- Moving LEFT at (0,224) with map_wall=0 -> map_addr=14*40+39=599, then x=624.
- Moving LEFT at x=303, request RIGHT -> applied immediately with no turn read, x=304; with SPEED_DIV=2, alternate frames leave x unchanged but still pulse position_ready.
- reset pulsed during FWD_WAIT -> no position_ready; outputs return to START values the next cycle; frame_start during UPDATE is ignored.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types and defaults for the Pac-Man motion controller.
// Orientation encoding: 0=RIGHT, 1=UP, 2=LEFT, 3=DOWN; the reverse of d is d^2.
package pacman_pkg;

  typedef logic [1:0] orient_t;

  localparam orient_t ORIENT_RIGHT = 2'd0;
  localparam orient_t ORIENT_UP    = 2'd1;
  localparam orient_t ORIENT_LEFT  = 2'd2;
  localparam orient_t ORIENT_DOWN  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN_RD,
    ST_TURN_WAIT,
    ST_FWD_RD,
    ST_FWD_WAIT,
    ST_UPDATE
  } state_t;

  // What the turn decision made at frame start will do once TURN_WAIT is reached.
  typedef enum logic [1:0] {
    TURN_NONE,
    TURN_CLEAR,
    TURN_REVERSE,
    TURN_READ
  } turn_t;

  localparam int DEF_TILE_SIZE = 16;
  localparam int DEF_MAP_COLS  = 40;
  localparam int DEF_MAP_ROWS  = 30;

  function automatic orient_t reverse_of(input orient_t d);
    return d ^ 2'd2;
  endfunction

endpackage

// File: rtl/pacman_tile_lookup.sv
// Combinational neighbour-tile address for a pixel position and direction.
// Horizontal edges wrap through the tunnel; vertical edges report a forced wall.
module pacman_tile_lookup
  import pacman_pkg::*;
#(
  parameter int TILE_SIZE = DEF_TILE_SIZE,
  parameter int MAP_COLS  = DEF_MAP_COLS,
  parameter int MAP_ROWS  = DEF_MAP_ROWS
) (
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  orient_t     dir,
  output logic [10:0] addr,
  output logic        force_wall,
  output logic        aligned
);

  localparam int          TILE_BITS = $clog2(TILE_SIZE);
  localparam logic [11:0] TILE_MASK = 12'(TILE_SIZE - 1);
  localparam logic [11:0] LAST_COL  = 12'(MAP_COLS - 1);
  localparam logic [11:0] LAST_ROW  = 12'(MAP_ROWS - 1);

  logic [11:0] col;
  logic [11:0] row;
  logic [11:0] ncol;
  logic [11:0] nrow;

  assign col     = x >> TILE_BITS;
  assign row     = y >> TILE_BITS;
  assign aligned = ((x & TILE_MASK) == 12'd0) && ((y & TILE_MASK) == 12'd0);

  always_comb begin
    ncol       = col;
    nrow       = row;
    force_wall = 1'b0;
    case (dir)
      ORIENT_RIGHT: ncol = (col == LAST_COL) ? 12'd0 : col + 12'd1;
      ORIENT_LEFT:  ncol = (col == 12'd0) ? LAST_COL : col - 12'd1;
      ORIENT_UP: begin
        if (row == 12'd0) force_wall = 1'b1;
        else              nrow = row - 12'd1;
      end
      default: begin
        if (row == LAST_ROW) force_wall = 1'b1;
        else                 nrow = row + 12'd1;
      end
    endcase
  end

  assign addr = 11'(nrow * 12'(MAP_COLS) + ncol);

endmodule

// File: rtl/pacman_motion_controller.sv
// Per-frame Pac-Man sprite motion: applies direction requests at tile centres,
// checks walls through a 1-cycle-latency maze port and steps one pixel per move frame.
module pacman_motion_controller
  import pacman_pkg::*;
#(
  parameter int TILE_SIZE = DEF_TILE_SIZE,
  parameter int MAP_COLS  = DEF_MAP_COLS,
  parameter int MAP_ROWS  = DEF_MAP_ROWS,
  parameter int START_X   = 304,
  parameter int START_Y   = 352,
  parameter int SPEED_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [1:0]  dir_req,
  input  logic        dir_req_valid,
  output logic        map_rd,
  output logic [10:0] map_addr,
  input  logic        map_wall,
  output logic [11:0] position_x,
  output logic [11:0] position_y,
  output logic [1:0]  orientation,
  output logic        position_ready,
  output state_t      fsm_state
);

  localparam logic [11:0] RESET_X  = 12'(START_X);
  localparam logic [11:0] RESET_Y  = 12'(START_Y);
  localparam logic [11:0] WRAP_X   = 12'((MAP_COLS - 1) * TILE_SIZE);
  localparam logic [3:0]  CNT_LAST = 4'(SPEED_DIV - 1);

  state_t      state;
  logic        pend_valid;
  orient_t     pend_dir;
  logic [3:0]  frame_cnt;
  logic        move_frame;
  turn_t       turn_act;
  orient_t     turn_dir;
  logic        fwd_read;
  logic        blocked;

  logic        turn_taken;
  orient_t     next_orient;
  orient_t     lk_dir;
  logic [10:0] lk_addr;
  logic        lk_force;
  logic        lk_aligned;

  assign fsm_state = state;

  // map_rd is raised on entry to TURN_RD/FWD_RD so map_wall is valid during the
  // following WAIT state and is sampled as that state ends.
  always_comb begin
    turn_taken = 1'b0;
    case (turn_act)
      TURN_REVERSE: turn_taken = 1'b1;
      TURN_READ:    turn_taken = !map_wall;
      default:      turn_taken = 1'b0;
    endcase
    next_orient = turn_taken ? turn_dir : orientation;
    lk_dir      = (state == ST_TURN_WAIT) ? next_orient : pend_dir;
  end

  pacman_tile_lookup #(
    .TILE_SIZE (TILE_SIZE),
    .MAP_COLS  (MAP_COLS),
    .MAP_ROWS  (MAP_ROWS)
  ) u_lookup (
    .x          (position_x),
    .y          (position_y),
    .dir        (lk_dir),
    .addr       (lk_addr),
    .force_wall (lk_force),
    .aligned    (lk_aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      position_x     <= RESET_X;
      position_y     <= RESET_Y;
      orientation    <= ORIENT_LEFT;
      position_ready <= 1'b0;
      map_rd         <= 1'b0;
      map_addr       <= 11'd0;
      pend_valid     <= 1'b0;
      pend_dir       <= ORIENT_RIGHT;
      frame_cnt      <= 4'd0;
      move_frame     <= 1'b0;
      turn_act       <= TURN_NONE;
      turn_dir       <= ORIENT_RIGHT;
      fwd_read       <= 1'b0;
      blocked        <= 1'b0;
    end else begin
      map_rd         <= 1'b0;
      position_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state      <= ST_TURN_RD;
            move_frame <= (frame_cnt == CNT_LAST);
            frame_cnt  <= (frame_cnt == CNT_LAST) ? 4'd0 : frame_cnt + 4'd1;
            turn_dir   <= pend_dir;
            turn_act   <= TURN_NONE;
            if (pend_valid) begin
              if (pend_dir == orientation) begin
                turn_act <= TURN_CLEAR;
              end else if (pend_dir == reverse_of(orientation)) begin
                turn_act <= TURN_REVERSE;
              end else if (lk_aligned && !lk_force) begin
                turn_act <= TURN_READ;
                map_rd   <= 1'b1;
                map_addr <= lk_addr;
              end
            end
          end
        end
        ST_TURN_RD: state <= ST_TURN_WAIT;
        ST_TURN_WAIT: begin
          state       <= ST_FWD_RD;
          orientation <= next_orient;
          if (turn_act == TURN_CLEAR || turn_taken) pend_valid <= 1'b0;
          fwd_read <= lk_aligned && !lk_force;
          blocked  <= lk_aligned && lk_force;
          if (lk_aligned && !lk_force) begin
            map_rd   <= 1'b1;
            map_addr <= lk_addr;
          end
        end
        ST_FWD_RD: state <= ST_FWD_WAIT;
        ST_FWD_WAIT: begin
          state <= ST_UPDATE;
          if (fwd_read) blocked <= map_wall;
        end
        ST_UPDATE: begin
          state          <= ST_IDLE;
          position_ready <= 1'b1;
          if (move_frame && !blocked) begin
            case (orientation)
              ORIENT_RIGHT: position_x <= (position_x == WRAP_X) ? 12'd0 : position_x + 12'd1;
              ORIENT_LEFT:  position_x <= (position_x == 12'd0) ? WRAP_X : position_x - 12'd1;
              ORIENT_UP:    position_y <= position_y - 12'd1;
              default:      position_y <= position_y + 12'd1;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A request arriving in the consuming cycle overrides the clear above.
      if (dir_req_valid) begin
        pend_valid <= 1'b1;
        pend_dir   <= dir_req;
      end
    end
  end

endmodule
